// File: rtl/wb_sram_responder.sv
// Pipelined Wishbone slave backed by a word-addressed SRAM with byte-enabled writes.
// Latency: ACK_LATENCY cycles from the accept edge to o_wb_ack (1..4), acks in accept order.
// Backpressure: one registered stall cycle after every STALL_EVERY accepts (0 = never stall).
module wb_sram_responder #(
    parameter int WB_ADDR_WIDTH  = 24,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = (WB_DATA_WIDTH + 7) / 8,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int ACK_LATENCY    = 1,
    parameter int STALL_EVERY    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_data,
    input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_data
);

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    // Counter only needs to reach STALL_EVERY-1; it clears on the Nth accept.
    localparam int CNT_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);

    logic [WB_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic                      accept;
    logic                      stall_q;
    logic [CNT_W-1:0]          acc_cnt;
    logic [WB_DATA_WIDTH-1:0]  rdata;
    logic [ACK_LATENCY-1:0]    pipe_vld;
    logic [WB_DATA_WIDTH-1:0]  pipe_dat [ACK_LATENCY];

    // Upper address bits alias onto the same words; they are intentionally dropped.
    generate
        if (WB_ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^i_wb_addr[WB_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
        end
    endgenerate

    assign idx    = i_wb_addr[MEM_ADDR_WIDTH-1:0];
    assign accept = i_wb_cyc & i_wb_stb & ~stall_q;

    // Byte-enabled write, committed at the accept edge; memory is never reset.
    always_ff @(posedge i_clk) begin
        if (accept && i_wb_we) begin
            for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                if (i_wb_sel[b]) begin
                    mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    // Read word seen by the accept edge; writes carry zero down the pipeline.
    always_comb begin
        rdata = '0;
        if (accept && !i_wb_we) begin
            rdata = mem[idx];
        end
    end

    // Ack shift register: stage 0 loads at accept, last stage drives the bus.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < ACK_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else if (!i_wb_cyc) begin
            // Dropping cyc abandons every outstanding transfer.
            pipe_vld <= '0;
            for (int i = 0; i < ACK_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_dat[0] <= rdata;
            for (int i = 1; i < ACK_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Stall generator: the Nth accept of a bus cycle raises stall for the next cycle only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_q <= 1'b0;
            acc_cnt <= '0;
        end else if (!i_wb_cyc || STALL_EVERY == 0) begin
            stall_q <= 1'b0;
            acc_cnt <= '0;
        end else if (accept) begin
            if (acc_cnt == CNT_LAST) begin
                stall_q <= 1'b1;
                acc_cnt <= '0;
            end else begin
                stall_q <= 1'b0;
                acc_cnt <= acc_cnt + 1'b1;
            end
        end else begin
            stall_q <= 1'b0;
        end
    end

    // Gating with cyc keeps ack/stall/data quiet the moment the master abandons the cycle.
    assign o_wb_ack   = pipe_vld[ACK_LATENCY-1] & i_wb_cyc;
    assign o_wb_stall = stall_q & i_wb_cyc;
    assign o_wb_data  = o_wb_ack ? pipe_dat[ACK_LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Scoreboard bench for wb_sram_responder: driver pushes expected acks, monitor pops.
// Reference: plain array memory, accept-count stall rule, fixed ack due cycle.
// Randomized traffic with idles, cyc drops and address aliasing, plus directed cases.
module tb_wb_sram_responder;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int MAW = 8;
    localparam int LAT = 3;
    localparam int SE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic          stall, ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat, rdat;
    logic [SW-1:0] sel;

    wb_sram_responder #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .WB_SEL_WIDTH  (SW),
        .MEM_ADDR_WIDTH(MAW),
        .ACK_LATENCY   (LAT),
        .STALL_EVERY   (SE)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .o_wb_stall(stall),
        .o_wb_ack  (ack),
        .i_wb_we   (we),
        .i_wb_addr (addr),
        .i_wb_data (wdat),
        .i_wb_sel  (sel),
        .o_wb_data (rdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [1 << MAW];
    int            cyc_n = 0;
    int            tests = 0;
    int            fails = 0;
    int            sess  = 0;
    bit            stall_pend = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Monitor: outputs sampled mid-cycle, compared against the reference rules.
    always @(negedge clk) begin : mon
        bit   exp_stall;
        bit   acc;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            sess       = 0;
            stall_pend = 1'b0;
        end else begin
            exp_stall = stall_pend && cyc;
            chk("stall", 32'(stall), 32'(exp_stall));
            if (!cyc) begin
                chk("ack_cyc_low", 32'(ack), 32'd0);
                exp_q.delete();
                sess       = 0;
                stall_pend = 1'b0;
            end else begin
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_ack", 32'(ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_cycle", 32'(cyc_n), 32'(e.due));
                        chk("ack_data", rdat, e.dat);
                    end
                end else begin
                    chk("idle_data", rdat, 32'd0);
                    if (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
                        e = exp_q.pop_front();
                        chk("missing_ack", 32'(ack), 32'd1);
                    end
                end
                acc = stb && !exp_stall;
                if (acc) sess++;
                stall_pend = acc && (SE > 0) && (sess % SE == 0);
            end
        end
    end

    // One transfer: hold stb until accepted, then record the expected response.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
        int   tries = 0;
        bit   done  = 1'b0;
        exp_t e;
        stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
        while (!done) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                if (w) begin
                    for (int b = 0; b < SW; b++) begin
                        if (s[b]) ref_mem[a[MAW-1:0]][8*b +: 8] = d[8*b +: 8];
                    end
                    e.dat = '0;
                end else begin
                    e.dat = ref_mem[a[MAW-1:0]];
                end
                e.due = cyc_n + LAT;
                exp_q.push_back(e);
            end else begin
                tries++;
                if (tries > 8) begin
                    chk("stall_timeout", 32'(stall), 32'd0);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdat = '0; sel = '0;
        @(posedge clk); #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data", rdat, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 1'b1;

        // Preload every word so all later reads have a known reference value.
        for (int i = 0; i < (1 << MAW); i++) xfer(1'b1, AW'(i), $urandom, 4'hF);

        // Full-word write then read back.
        xfer(1'b1, 24'h10, 32'hDEADBEEF, 4'hF);
        xfer(1'b0, 24'h10, 32'h0, 4'h0);

        // Partial byte write merges into existing word.
        xfer(1'b1, 24'h5, 32'h11223344, 4'hF);
        xfer(1'b1, 24'h5, 32'hAABBCCDD, 4'b0101);
        xfer(1'b0, 24'h5, 32'h0, 4'h0);

        // Back-to-back reads in address order.
        for (int i = 0; i < 8; i++) xfer(1'b0, AW'(i), 32'h0, 4'h0);
        idle(LAT + 2);

        // Abort with reads outstanding, then restart.
        for (int i = 0; i < 3; i++) xfer(1'b0, AW'(i + 20), 32'h0, 4'h0);
        cyc = 1'b0;
        idle(1);
        cyc = 1'b1;
        for (int i = 0; i < 4; i++) xfer(1'b0, AW'(i + 30), 32'h0, 4'h0);

        // Randomized traffic with idles and cyc drops.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                cyc = 1'b0;
                idle($urandom_range(1, 2));
                cyc = 1'b1;
            end else if (r == 1) begin
                idle(1);
            end else begin
                xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom));
            end
        end

        // Upper address bits alias onto the same word.
        xfer(1'b1, 24'h000103, 32'h0000005A, 4'hF);
        xfer(1'b0, 24'h000003, 32'h0, 4'h0);
        idle(LAT + 2);

        // Reset while an ack is on the bus and another is pending.
        cyc = 1'b0;
        idle(1);
        cyc = 1'b1;
        xfer(1'b0, 24'h1, 32'h0, 4'h0);
        xfer(1'b0, 24'h2, 32'h0, 4'h0);
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(ack), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_data", rdat, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Traffic resumes cleanly after reset.
        xfer(1'b1, 24'h20, 32'hCAFEF00D, 4'hF);
        xfer(1'b0, 24'h20, 32'h0, 4'h0);
        idle(LAT + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
